// File: rtl/contador_multimodo.sv
// contador_multimodo: parametrised up/down/ping-pong counter with load, wrap or saturate,
// terminal-count pulse, Gray output and a saturating terminal-count event counter.
module contador_multimodo #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] contador,
  output logic [WIDTH-1:0] contador_gray,
  output logic             dir,
  output logic             tc,
  output logic [7:0]       n_tc
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d, tc_q, tc_d;
  logic [7:0]       n_q, n_d;
  logic             at_top, at_bot;
  always_comb begin
    at_top = cnt_q == TOP;
    at_bot = cnt_q == '0;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    tc_d   = 1'b0;
    if (load) cnt_d = load_val > TOP ? TOP : load_val;
    else if (en)
      case (mode)
        2'b00: begin
          dir_d = 1'b0;
          cnt_d = cnt_q < TOP ? cnt_q + ONE : (SAT && at_top ? TOP : '0);
          tc_d  = cnt_q < TOP ? SAT && cnt_q + ONE == TOP : !SAT && at_top;
        end
        2'b01: begin
          dir_d = 1'b1;
          cnt_d = at_bot ? (SAT ? '0 : TOP) : cnt_q - ONE;
          tc_d  = at_bot ? !SAT : SAT && cnt_q == ONE;
        end
        2'b10: begin
          // reversal happens on the edge leaving the bound, so the pulse lines up with the turned value
          dir_d = dir_q ? !at_bot : at_top;
          cnt_d = dir_q ? (at_bot ? ONE : cnt_q - ONE) : (at_top ? TOP - ONE : cnt_q + ONE);
          tc_d  = dir_q ? at_bot : at_top;
        end
        default: tc_d = 1'b0;
      endcase
    n_d = tc_d && n_q != 8'hff ? n_q + 8'd1 : n_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
      n_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
      n_q   <= n_d;
    end
  assign contador      = cnt_q;
  assign contador_gray = cnt_q ^ (cnt_q >> 1);
  assign dir           = dir_q;
  assign tc            = tc_q;
  assign n_tc          = n_q;
endmodule

// File: tb/tb_contador_multimodo.sv
// tb_contador_multimodo: scoreboard bench driving four counter configurations with shared stimulus,
// checked against an unfolded-period reference model.
`timescale 1ns/1ps
module tb_contador_multimodo;
  localparam int N = 4;
  localparam int MX [N] = '{9, 9, 5, 1};
  localparam int SV [N] = '{0, 1, 0, 0};
  typedef struct packed { logic [3:0] c; logic d; logic t; logic [7:0] n; } st_t;
  typedef st_t [N-1:0] row_t;
  logic clk = 0, reset = 0, en = 0, load = 0;
  logic [1:0] mode = 0;
  logic [3:0] load_val = 0;
  logic [3:0] cnt_w [N];
  logic [3:0] gray_w [N];
  logic       dir_w [N];
  logic       tc_w [N];
  logic [7:0] n_w [N];
  row_t sb [$];
  row_t mr;
  int mc [N], md [N], mt [N], mn [N];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  contador_multimodo #(.WIDTH(4), .MAX(9), .SAT(1'b0)) u_a (.clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .contador(cnt_w[0]), .contador_gray(gray_w[0]), .dir(dir_w[0]), .tc(tc_w[0]), .n_tc(n_w[0]));
  contador_multimodo #(.WIDTH(4), .MAX(9), .SAT(1'b1)) u_b (.clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .contador(cnt_w[1]), .contador_gray(gray_w[1]), .dir(dir_w[1]), .tc(tc_w[1]), .n_tc(n_w[1]));
  contador_multimodo #(.WIDTH(4), .MAX(5), .SAT(1'b0)) u_c (.clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .contador(cnt_w[2]), .contador_gray(gray_w[2]), .dir(dir_w[2]), .tc(tc_w[2]), .n_tc(n_w[2]));
  contador_multimodo #(.WIDTH(4), .MAX(1), .SAT(1'b0)) u_d (.clk(clk), .reset(reset), .en(en), .mode(mode),
    .load(load), .load_val(load_val), .contador(cnt_w[3]), .contador_gray(gray_w[3]), .dir(dir_w[3]), .tc(tc_w[3]), .n_tc(n_w[3]));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // ping-pong is modelled as a walk around a ring of 2*MAX positions, folded back onto 0..MAX
  function automatic void model(input int i, input bit l, input int lv, input bit e, input int m);
    int p, p2;
    mt[i] = 0;
    if (l) mc[i] = lv > MX[i] ? MX[i] : lv;
    else if (e && m == 0) begin
      md[i] = 0;
      if (SV[i] != 0) begin
        mt[i] = int'(mc[i] == MX[i] - 1);
        mc[i] = mc[i] < MX[i] ? mc[i] + 1 : MX[i];
      end else begin
        mt[i] = int'(mc[i] == MX[i]);
        mc[i] = (mc[i] + 1) % (MX[i] + 1);
      end
    end else if (e && m == 1) begin
      md[i] = 1;
      if (SV[i] != 0) begin
        mt[i] = int'(mc[i] == 1);
        mc[i] = mc[i] > 0 ? mc[i] - 1 : 0;
      end else begin
        mt[i] = int'(mc[i] == 0);
        mc[i] = (mc[i] + MX[i]) % (MX[i] + 1);
      end
    end else if (e && m == 2) begin
      p = md[i] != 0 ? 2 * MX[i] - mc[i] : mc[i];
      mt[i] = int'((p == MX[i] && md[i] == 0) || p == 2 * MX[i]);
      p2 = p + 1;
      if (p2 > 2 * MX[i]) p2 = 1;
      mc[i] = p2 <= MX[i] ? p2 : 2 * MX[i] - p2;
      md[i] = int'(p2 > MX[i]);
    end
    if (mt[i] != 0) mn[i] = mn[i] < 255 ? mn[i] + 1 : 255;
  endfunction
  task automatic step(input bit l, input int lv, input bit e, input int m);
    row_t r;
    @(negedge clk);
    load = l;
    load_val = 4'(lv);
    en = e;
    mode = 2'(m);
    for (int i = 0; i < N; i++) begin
      model(i, l, lv, e, m);
      r[i].c = 4'(mc[i]);
      r[i].d = md[i][0];
      r[i].t = mt[i][0];
      r[i].n = 8'(mn[i]);
    end
    sb.push_back(r);
  endtask
  task automatic do_reset();
    @(negedge clk);
    en = 0;
    load = 0;
    #2 reset = 1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_cnt[%0d]", i), cnt_w[i], 0);
      chk($sformatf("rst_gray[%0d]", i), gray_w[i], 0);
      chk($sformatf("rst_dir[%0d]", i), dir_w[i], 0);
      chk($sformatf("rst_tc[%0d]", i), tc_w[i], 0);
      chk($sformatf("rst_ntc[%0d]", i), n_w[i], 0);
      mc[i] = 0;
      md[i] = 0;
      mt[i] = 0;
      mn[i] = 0;
    end
    @(negedge clk);
    reset = 0;
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mr = sb.pop_front();
      for (int i = 0; i < N; i++) begin
        chk($sformatf("cnt[%0d]", i), cnt_w[i], mr[i].c);
        chk($sformatf("gray[%0d]", i), gray_w[i], mr[i].c ^ (mr[i].c >> 1));
        chk($sformatf("dir[%0d]", i), dir_w[i], mr[i].d);
        chk($sformatf("tc[%0d]", i), tc_w[i], mr[i].t);
        chk($sformatf("ntc[%0d]", i), n_w[i], mr[i].n);
      end
    end
  end
  initial begin
    do_reset();
    repeat (6) step(0, 0, 1, 0);
    do_reset();
    repeat (24) step(0, 0, 1, 0);
    @(posedge clk); #2;
    chk("upwrap_cnt", cnt_w[0], 4);
    chk("upwrap_ntc", n_w[0], 2);
    step(1, 3, 1, 1);
    repeat (5) step(0, 0, 1, 1);
    @(posedge clk); #2;
    chk("satdown_cnt", cnt_w[1], 0);
    chk("satdown_dir", dir_w[1], 1);
    do_reset();
    repeat (11) step(0, 0, 1, 2);
    @(posedge clk); #2;
    chk("pp_cnt", cnt_w[2], 1);
    chk("pp_dir", dir_w[2], 0);
    chk("pp_ntc", n_w[2], 2);
    step(1, 14, 1, 0);
    @(posedge clk); #2;
    chk("clamp_cnt", cnt_w[0], 9);
    chk("clamp_gray", gray_w[0], 4'b1101);
    chk("clamp_tc", tc_w[0], 0);
    step(1, 6, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 2);
    repeat (3) step(0, 0, 1, 3);
    @(posedge clk); #2;
    chk("hold_cnt", cnt_w[0], 8);
    chk("hold_dir", dir_w[0], 1);
    chk("hold_tc", tc_w[0], 0);
    do_reset();
    repeat (300) step(0, 0, 1, 2);
    @(posedge clk); #2;
    chk("ntc_sat", n_w[3], 255);
    repeat (400) step($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
    @(posedge clk); #2;
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
